// File: rtl/wallace_pkg.sv
// wallace_pkg: shared widths, latency and tree-shape helpers; LATENCY depends on WALLACE_PIPELINE_EN
package wallace_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int PROD_W = 64;
`ifdef WALLACE_PIPELINE_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 2;
`endif
  function automatic int next_rows(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction
  function automatic int rows_at(input int n, input int l);
    int r;
    r = n;
    for (int j = 0; j < l; j++) r = next_rows(r);
    return r;
  endfunction
  function automatic int num_layers(input int n);
    int r;
    int c;
    r = n;
    c = 0;
    while (r > 2) begin
      r = next_rows(r);
      c++;
    end
    return c;
  endfunction
endpackage

// File: rtl/wallace_fa.sv
// wallace_fa: 1-bit full adder (a, b, cin -> sum, cout); half adder when cin is tied to 0
module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/wallace.sv
// wallace: pipelined unsigned Wallace-tree multiplier, out = a*b after LATENCY edges; ports a, b, out, clk, rst_n (async active-low); WALLACE_PIPELINE_EN adds a register bank before the CPA
module wallace
  import wallace_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out,
  input  logic               clk,
  input  logic               rst_n
);
  localparam int PW = 2 * WIDTH;
  localparam int NL = num_layers(WIDTH);
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0] rows [NL+1][WIDTH];
  logic [PW-1:0] prod_d;
  genvar i, l, g, k, r;
  for (i = 0; i < WIDTH; i++) begin : g_pp
    assign rows[0][i] = {{WIDTH{1'b0}}, a_q & {WIDTH{b_q[i]}}} << i;
  end
  // Each layer compresses every group of three rows into a sum row and a
  // left-shifted carry row; leftover rows pass straight to the next layer.
  // Carries out of the top bit are dropped: the product always fits in PW bits.
  for (l = 0; l < NL; l++) begin : g_lay
    localparam int N = rows_at(WIDTH, l);
    localparam int G = N / 3;
    localparam int M = next_rows(N);
    for (g = 0; g < G; g++) begin : g_grp
      logic [PW-1:0] s, c;
      for (k = 0; k < PW; k++) begin : g_bit
        wallace_fa u_fa (
          .a   (rows[l][3*g][k]),
          .b   (rows[l][3*g+1][k]),
          .cin (rows[l][3*g+2][k]),
          .sum (s[k]),
          .cout(c[k])
        );
      end
      assign rows[l+1][2*g]   = s;
      assign rows[l+1][2*g+1] = {c[PW-2:0], 1'b0};
    end
    for (r = 0; r < N % 3; r++) begin : g_pass
      assign rows[l+1][2*G+r] = rows[l][3*G+r];
    end
    for (r = M; r < WIDTH; r++) begin : g_zero
      assign rows[l+1][r] = '0;
    end
  end
`ifdef WALLACE_PIPELINE_EN
  logic [PW-1:0] s_q, c_q;
  assign prod_d = s_q + c_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= '0;
    end else begin
      s_q <= rows[NL][0];
      c_q <= rows[NL][1];
    end
  end
`else
  assign prod_d = rows[NL][0] + rows[NL][1];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      out <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
      out <= prod_d;
    end
  end
endmodule

// File: tb/tb_wallace.sv
// tb_wallace: scoreboard bench for wallace; expected products queued at issue, checked by a monitor
module tb_wallace;
`ifdef WALLACE_PIPELINE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, rst_n = 0, issue = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] out;
  logic [LAT-1:0] vs;
  logic [63:0] q [$];
  int n_chk = 0, n_err = 0;

  wallace dut (.a(a), .b(b), .out(out), .clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) vs <= '0;
    else vs <= {vs[LAT-2:0], issue};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && vs[LAT-1]) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL queue_underflow: got out %h with no expected entry", out);
      end else chk("product", out, q.pop_front());
    end

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a = x;
    b = y;
    issue = 1;
    q.push_back({32'b0, x} * {32'b0, y});
  endtask

  initial begin
    #2 chk("reset_out", out, 64'd0);
    a = 40;
    b = 95;
    @(posedge clk);
    #1 chk("reset_hold_out", out, 64'd0);
    @(negedge clk);
    rst_n = 1;
    issue = 1;
    q.push_back(64'd3800);
    repeat (LAT - 1) begin
      @(posedge clk);
      #1 chk("pre_latency_zero", out, 64'd0);
      send(40, 95);
    end
    repeat (4) send(40, 95);
    send(32'hFFFFFFFF, 32'hFFFFFFFF);
    send(32'h0, 32'hDEADBEEF);
    send(32'hDEADBEEF, 32'h0);
    send(3, 5);
    send(7, 11);
    send(65536, 65536);
    send(1, 32'hFFFFFFFF);
    send(32'h80000000, 2);
    @(posedge clk);
    #2 rst_n = 0;
    issue = 0;
    q.delete();
    #1 chk("async_reset_out", out, 64'd0);
    @(posedge clk);
    #1 chk("reset_hold_out2", out, 64'd0);
    @(negedge clk);
    a = 12345;
    b = 678;
    rst_n = 1;
    issue = 1;
    q.push_back(64'd8369910);
    repeat (LAT - 1) begin
      @(posedge clk);
      #1 chk("post_reset_zero", out, 64'd0);
      send(12345, 678);
    end
    repeat (10000) send($urandom, $urandom);
    @(negedge clk);
    issue = 0;
    repeat (LAT + 1) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got %0d checks", n_chk);
    $fatal(1, "timeout");
  end
endmodule
